color_to_memory: RTL

- Write-side counterpart of the frame-buffer colour read path.
- Accepts a stream of pixels through a valid/ready handshake and packs them into 32-bit memory words with byte-lane selects, at 8-, 16- or 32-bit colour depth.
- Issues each word to the memory write port with an auto-incrementing byte address.
- Sits between the pixel generator and the frame-buffer memory arbiter.

---
 rtl/color_pkg.sv | 25 ++
 rtl/color_lane_place.sv | 47 ++++
 rtl/color_to_memory.sv | 107 ++++++++++
 3 files changed

// File: rtl/color_pkg.sv
// Shared colour-depth encodings, FSM state type and slot helper for the
// frame-buffer colour read and write paths.
package color_pkg;

  localparam logic [1:0] DEPTH_8    = 2'b00;
  localparam logic [1:0] DEPTH_16   = 2'b01;
  localparam logic [1:0] DEPTH_32   = 2'b10;
  localparam logic [1:0] DEPTH_RSVD = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Pixels per 32-bit word; reserved depth never completes a word, so its value is moot.
  function automatic logic [2:0] slots_per_word(input logic [1:0] depth);
    case (depth)
      DEPTH_8:  slots_per_word = 3'd4;
      DEPTH_16: slots_per_word = 3'd2;
      DEPTH_32: slots_per_word = 3'd1;
      default:  slots_per_word = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/color_lane_place.sv
// Places one right-aligned pixel into its byte lanes for a given slot.
// Optional COLOR_LITTLE_ENDIAN_EN puts slot 0 in the low lanes instead of the high lanes.
module color_lane_place
  import color_pkg::*;
(
  input  logic [1:0]  depth,
  input  logic [1:0]  slot,
  input  logic [31:0] pix,
  output logic [31:0] lane_data,
  output logic [3:0]  lane_sel
);

  logic [1:0] byte_lane;
  logic       half_lane;

`ifdef COLOR_LITTLE_ENDIAN_EN
  assign byte_lane = slot;
  assign half_lane = slot[0];
`else
  assign byte_lane = 2'd3 - slot;
  assign half_lane = ~slot[0];
`endif

  always_comb begin
    lane_data = '0;
    lane_sel  = '0;
    case (depth)
      DEPTH_8: begin
        lane_data[{byte_lane, 3'b000} +: 8] = pix[7:0];
        lane_sel[byte_lane]                 = 1'b1;
      end
      DEPTH_16: begin
        lane_data[{half_lane, 4'b0000} +: 16] = pix[15:0];
        lane_sel[{half_lane, 1'b0} +: 2]      = 2'b11;
      end
      DEPTH_32: begin
        lane_data = pix;
        lane_sel  = 4'b1111;
      end
      default: begin
        lane_data = '0;
        lane_sel  = '0;
      end
    endcase
  end

endmodule

// File: rtl/color_to_memory.sv
// Packs a valid/ready pixel stream into 32-bit memory words with byte selects
// and auto-incrementing word addresses. Lane order option: COLOR_LITTLE_ENDIAN_EN.
//
// state | meaning
// IDLE  | no run configured, pixels refused
// RUN   | packing pixels into the accumulator, emitting completed words
module color_to_memory
  import color_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [1:0]        color_depth_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              pix_valid_i,
  output logic              pix_ready_o,
  input  logic [31:0]       pix_i,
  input  logic              pix_last_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [31:0]       mem_o,
  output logic [3:0]        sel_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              err_o
);

  state_e            state_q;
  logic [1:0]        depth_q;
  logic [1:0]        slot_q;
  logic [31:0]       acc_data_q;
  logic [3:0]        acc_sel_q;
  logic [ADDR_W-1:0] wr_addr_q;

  logic [31:0] lane_data;
  logic [3:0]  lane_sel;
  logic [2:0]  slots;
  logic        rsvd;
  logic        would_complete;
  logic        pix_fire;

  color_lane_place u_lane_place (
    .depth     (depth_q),
    .slot      (slot_q),
    .pix       (pix_i),
    .lane_data (lane_data),
    .lane_sel  (lane_sel)
  );

  assign slots          = slots_per_word(depth_q);
  assign rsvd           = (depth_q == DEPTH_RSVD);
  assign would_complete = !rsvd && (pix_last_i || ({1'b0, slot_q} == slots - 3'd1));

  // A start cycle reconfigures the packer, so no pixel is taken in it.
  assign pix_ready_o = (state_q == RUN) && !start_i &&
                       !(mem_valid_o && !mem_ready_i && would_complete);
  assign pix_fire    = pix_valid_i && pix_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      depth_q     <= DEPTH_8;
      slot_q      <= '0;
      acc_data_q  <= '0;
      acc_sel_q   <= '0;
      wr_addr_q   <= '0;
      mem_valid_o <= 1'b0;
      mem_o       <= '0;
      sel_o       <= '0;
      mem_addr_o  <= '0;
      err_o       <= 1'b0;
    end else begin
      if (mem_valid_o && mem_ready_i) begin
        mem_valid_o <= 1'b0;
      end
      if (start_i) begin
        state_q    <= RUN;
        depth_q    <= color_depth_i;
        wr_addr_q  <= {base_addr_i[ADDR_W-1:2], 2'b00};
        slot_q     <= '0;
        acc_data_q <= '0;
        acc_sel_q  <= '0;
        err_o      <= 1'b0;
      end else if (pix_fire) begin
        if (rsvd) begin
          err_o <= 1'b1;
        end else if (would_complete) begin
          // Ready guarantees the output register is empty or draining now.
          mem_valid_o <= 1'b1;
          mem_o       <= acc_data_q | lane_data;
          sel_o       <= acc_sel_q | lane_sel;
          mem_addr_o  <= wr_addr_q;
          wr_addr_q   <= wr_addr_q + ADDR_W'(4);
          slot_q      <= '0;
          acc_data_q  <= '0;
          acc_sel_q   <= '0;
        end else begin
          acc_data_q <= acc_data_q | lane_data;
          acc_sel_q  <= acc_sel_q | lane_sel;
          slot_q     <= slot_q + 2'd1;
        end
      end
    end
  end

endmodule
